dmem_arbiter: RTL

Two-requester arbiter and access sequencer for the data memory (11-bit word address, 32-bit data, write on clock edge, combinational read). Requester 0 is the CPU load/store port and requester 1 is the DMA/debug loader port. The block grants at most one requester per cycle, drives the memory enable and read/write strobes, and returns registered read data with a one-cycle acknowledge. It uses round-robin fairness and supports an optional bounded lock for bursts.

---
 rtl/dmem_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin data-memory arbiter with bounded burst lock
module dmem_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_ena,
    output logic              mem_w,
    output logic              mem_r,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BMAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_e;

    state_e            state_q, state_d, own_lock;
    logic [BW-1:0]     burst_q, burst_d;
    logic              rr_q, rr_d;
    logic              ack0_q, ack1_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              hold0, hold1, keep0, keep1, g0, g1, gnt_lock;

    // Grant decision: a live lock owner keeps the port until the burst limit is hit
    // while the other side waits; otherwise round-robin. Grants are suppressed while
    // reset is asserted so no access (and no write) can start mid-reset.
    always_comb begin
        hold0 = (state_q == LOCK0) && req0;
        hold1 = (state_q == LOCK1) && req1;
        keep0 = hold0 && ((burst_q < BMAX) || !req1);
        keep1 = hold1 && ((burst_q < BMAX) || !req0);
        g0    = hold0 ? keep0 : hold1 ? !keep1 : req0 && (!req1 || !rr_q);
        g1    = hold1 ? keep1 : hold0 ? !keep0 : req1 && (!req0 || rr_q);
        gnt0  = rst_n && g0;
        gnt1  = rst_n && g1;
    end

    // Memory-side mux from the granted requester; everything reads 0 when idle
    always_comb begin
        mem_ena   = gnt0 | gnt1;
        mem_w     = (gnt0 && we0) || (gnt1 && we1);
        mem_r     = (gnt0 && !we0) || (gnt1 && !we1);
        mem_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
        mem_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    end

    // Next lock state, saturating burst count and round-robin pointer
    always_comb begin
        gnt_lock = gnt0 ? lock0 : (gnt1 && lock1);
        own_lock = gnt0 ? LOCK0 : LOCK1;
        state_d  = gnt_lock ? own_lock : IDLE;
        burst_d  = !gnt_lock ? '0 :
                   (state_q != own_lock) ? BW'(1) :
                   (burst_q == BMAX) ? burst_q : burst_q + 1'b1;
        rr_d     = (gnt0 | gnt1) ? gnt0 : rr_q;
    end

    // Arbiter state plus registered acknowledge and read-data return per requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            burst_q  <= '0;
            rr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            rr_q    <= rr_d;
            ack0_q  <= gnt0;
            ack1_q  <= gnt1;
            if (gnt0 && !we0) rdata0_q <= mem_rdata;
            if (gnt1 && !we1) rdata1_q <= mem_rdata;
        end
    end

    assign ack0   = ack0_q;
    assign ack1   = ack1_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
endmodule
